// File: rtl/seg_scan_driver_if.sv
// Load/ready handshake carrying one display update (nibbles plus decimal points)
// from the producer into seg_scan_driver.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      ready;

    modport master (
        output load,
        output data_in,
        output dp_in,
        input  ready
    );

    modport slave (
        input  load,
        input  data_in,
        input  dp_in,
        output ready
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned updates and
// leading-zero suppression; define SEGSCAN_BLINK_EN to add per-digit blinking.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIV_WIDTH   = 11,
    parameter int BLINK_WIDTH = 24,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_driver_if.slave      bus,
    input  logic                  lz_blank,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic [IDX_W-1:0]      idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp_nib;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_nib;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_v;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;

    logic w_tick;
    logic w_wrap;
    logic w_accept;
    logic w_commit;

    assign w_tick   = &r_div_cnt;
    assign w_wrap   = w_tick && (r_idx == LAST_IDX);
    assign w_accept = bus.load && !r_pend_v;
    // Commit only as the scan wraps so a frame never shows a mix of old and new data.
    assign w_commit = w_wrap && r_pend_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_idx      <= '0;
            r_disp_nib <= '0;
            r_disp_dp  <= '0;
            r_pend_nib <= '0;
            r_pend_dp  <= '0;
            r_pend_v   <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end
            if (w_accept) begin
                r_pend_nib <= bus.data_in;
                r_pend_dp  <= bus.dp_in;
                r_pend_v   <= 1'b1;
            end else if (w_commit) begin
                r_disp_nib <= r_pend_nib;
                r_disp_dp  <= r_pend_dp;
                r_pend_v   <= 1'b0;
            end
        end
    end

    assign bus.ready = !r_pend_v;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'h0:    segs = 7'b0000001;
            4'h1:    segs = 7'b1001111;
            4'h2:    segs = 7'b0010010;
            4'h3:    segs = 7'b0000110;
            4'h4:    segs = 7'b1001100;
            4'h5:    segs = 7'b0100100;
            4'h6:    segs = 7'b0100000;
            4'h7:    segs = 7'b0001111;
            4'h8:    segs = 7'b0000000;
            4'h9:    segs = 7'b0000100;
            4'hA:    segs = 7'b0001000;
            4'hB:    segs = 7'b1100000;
            4'hC:    segs = 7'b0110001;
            4'hD:    segs = 7'b1000010;
            4'hE:    segs = 7'b0110000;
            default: segs = 7'b0111000;
        endcase
        return segs;
    endfunction

    // Per scan position views; position 0 is the leftmost, most significant nibble.
    logic [3:0] w_pos_nib   [NUM_DIGITS];
    logic       w_pos_dp    [NUM_DIGITS];
    logic       w_pos_zero  [NUM_DIGITS];
    logic       w_pos_blank [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            assign w_pos_nib[gi] = r_disp_nib[4*(NUM_DIGITS-1-gi) +: 4];
            assign w_pos_dp[gi]  = r_disp_dp[NUM_DIGITS-1-gi];

            if (gi == 0) begin : g_first
                assign w_pos_zero[gi] = (w_pos_nib[gi] == 4'h0);
            end else begin : g_rest
                assign w_pos_zero[gi] = w_pos_zero[gi-1] && (w_pos_nib[gi] == 4'h0);
            end

            if (gi == NUM_DIGITS - 1) begin : g_last
                assign w_pos_blank[gi] = 1'b0;
            end else begin : g_lead
                assign w_pos_blank[gi] = lz_blank && w_pos_zero[gi];
            end
        end
    endgenerate

    logic [3:0] w_cur_nib;
    logic       w_cur_dp;
    logic       w_cur_blank;
    logic       w_blink_off;

    assign w_cur_nib   = w_pos_nib[r_idx];
    assign w_cur_dp    = w_pos_dp[r_idx];
    assign w_cur_blank = w_pos_blank[r_idx];

`ifdef SEGSCAN_BLINK_EN
    logic [BLINK_WIDTH-1:0] r_blink_cnt;
    logic                   w_pos_bmask [NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_WIDTH'(1);
        end
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_bmask
            assign w_pos_bmask[gi] = blink_mask[NUM_DIGITS-1-gi];
        end
    endgenerate

    assign w_blink_off = r_blink_cnt[BLINK_WIDTH-1] && w_pos_bmask[r_idx];
`else
    logic w_unused_blink;

    assign w_unused_blink = (^blink_mask) ^ (BLINK_WIDTH > 0);
    assign w_blink_off    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= 8'hFF;
        end else begin
            r_an <= ~(NUM_DIGITS'(1) << r_idx);
            if (w_cur_blank || w_blink_off) begin
                r_seg <= 8'hFF;
            end else begin
                r_seg <= {f_decode(w_cur_nib), ~w_cur_dp};
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign idx = r_idx;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected per-position segment patterns are
// queued when an update is loaded and popped as the scanner shows each position.
module tb_seg_scan_driver;

    localparam int N  = 8;
    localparam int DW = 2;
    localparam int BW = 4;
    localparam int IW = 3;
    localparam int POS_CYCLES = 1 << DW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lz_blank;
    logic [N-1:0] blink_mask;
    logic [N-1:0] an;
    logic [7:0]   seg;
    logic [IW-1:0] idx;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int         pos;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .DIV_WIDTH  (DW),
        .BLINK_WIDTH(BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .lz_blank  (lz_blank),
        .blink_mask(blink_mask),
        .an        (an),
        .seg       (seg),
        .idx       (idx)
    );

    function automatic logic [6:0] ref_seg7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0: r = 7'b0000001;  4'h1: r = 7'b1001111;
            4'h2: r = 7'b0010010;  4'h3: r = 7'b0000110;
            4'h4: r = 7'b1001100;  4'h5: r = 7'b0100100;
            4'h6: r = 7'b0100000;  4'h7: r = 7'b0001111;
            4'h8: r = 7'b0000000;  4'h9: r = 7'b0000100;
            4'hA: r = 7'b0001000;  4'hB: r = 7'b1100000;
            4'hC: r = 7'b0110001;  4'hD: r = 7'b1000010;
            4'hE: r = 7'b0110000;  default: r = 7'b0111000;
        endcase
        return r;
    endfunction

    // Queue the eight positions a frame of this data is expected to show.
    task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input logic lz);
        logic       zero_run;
        logic [3:0] nib;
        exp_t       e;
        zero_run = 1'b1;
        for (int p = 0; p < N; p++) begin
            nib      = d[4*(N-1-p) +: 4];
            zero_run = zero_run && (nib == 4'h0);
            e.pos    = p;
            if (lz && zero_run && (p != N-1)) e.seg = 8'hFF;
            else                              e.seg = {ref_seg7(nib), ~dp[N-1-p]};
            sb.push_back(e);
        end
    endtask

    // Called at the first negedge on which position 0 of a frame is visible.
    task automatic check_frame(input string name);
        exp_t         e;
        logic [N-1:0] exp_an;
        for (int p = 0; p < N; p++) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL %s pos%0d: scoreboard empty, an=%b seg=%b", name, p, an, seg);
            end else begin
                e      = sb.pop_front();
                exp_an = ~(8'h01 << e.pos);
                if (an !== exp_an || seg !== e.seg) begin
                    tests_failed++;
                    $display("FAIL %s pos%0d: an=%b seg=%b, expected an=%b seg=%b",
                             name, e.pos, an, seg, exp_an, e.seg);
                end else begin
                    $display("[TB] %s pos%0d an=%b seg=%b ok", name, e.pos, an, seg);
                end
            end
            repeat (POS_CYCLES) @(negedge clk);
        end
    endtask

    task automatic drive_load(input logic [31:0] d, input logic [7:0] dp, input string name);
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready before load: got %b, expected 1", name, bus.ready);
        end
        bus.load    = 1'b1;
        bus.data_in = d;
        bus.dp_in   = dp;
        @(negedge clk);
        bus.load = 1'b0;
        tests_run++;
        if (bus.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s ready after accept: got %b, expected 0", name, bus.ready);
        end
        $display("[TB] %s load data=%h dp=%h", name, d, dp);
    endtask

    // Wait for ready to rise; it must coincide with the scan wrapping to position 0.
    task automatic wait_commit(input string name);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s commit timeout: ready=%b after %0d cycles, expected 1", name, bus.ready, n);
        end
        tests_run++;
        if (idx !== '0) begin
            tests_failed++;
            $display("FAIL %s commit position: idx=%0d, expected 0", name, idx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (an !== 8'hFF) begin tests_failed++; $display("FAIL reset an: got %b, expected 11111111", an); end
        tests_run++;
        if (seg !== 8'hFF) begin tests_failed++; $display("FAIL reset seg: got %b, expected 11111111", seg); end
        tests_run++;
        if (bus.ready !== 1'b1) begin tests_failed++; $display("FAIL reset ready: got %b, expected 1", bus.ready); end
        tests_run++;
        if (idx !== '0) begin tests_failed++; $display("FAIL reset idx: got %0d, expected 0", idx); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (an !== 8'hFE) begin tests_failed++; $display("FAIL first an: got %b, expected 11111110", an); end
        tests_run++;
        if (seg !== 8'h03) begin tests_failed++; $display("FAIL first seg: got %b, expected 00000011", seg); end
        $display("[TB] reset released an=%b seg=%b", an, seg);
        push_frame(32'h0, 8'h00, 1'b0);
        check_frame("reset_frame");
    endtask

    task automatic test_data();
        drive_load(32'h12345678, 8'h01, "data");
        push_frame(32'h12345678, 8'h01, 1'b0);
        wait_commit("data");
        check_frame("data");
    endtask

    task automatic test_lz();
        lz_blank = 1'b1;
        drive_load(32'h00000450, 8'h00, "lz450");
        push_frame(32'h00000450, 8'h00, 1'b1);
        wait_commit("lz450");
        check_frame("lz450");
        drive_load(32'h00000000, 8'h00, "lz0");
        push_frame(32'h00000000, 8'h00, 1'b1);
        wait_commit("lz0");
        check_frame("lz0");
        lz_blank = 1'b0;
    endtask

    task automatic test_busy_load();
        drive_load(32'h11111111, 8'h00, "busy");
        push_frame(32'h11111111, 8'h00, 1'b0);
        bus.load    = 1'b1;
        bus.data_in = 32'hAAAAAAAA;
        bus.dp_in   = 8'hFF;
        @(negedge clk);
        bus.load = 1'b0;
        tests_run++;
        if (bus.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy ready after ignored load: got %b, expected 0", bus.ready);
        end
        wait_commit("busy");
        check_frame("busy");
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy ignored load latched: ready=%b, expected 1", bus.ready);
        end
    endtask

    task automatic test_reset_mid();
        drive_load(32'hDEADBEEF, 8'hFF, "rst_mid");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid ready: got %b, expected 1", bus.ready); end
        tests_run++;
        if (idx !== '0) begin tests_failed++; $display("FAIL rst_mid idx: got %0d, expected 0", idx); end
        tests_run++;
        if (an !== 8'hFF || seg !== 8'hFF) begin
            tests_failed++;
            $display("FAIL rst_mid outputs: an=%b seg=%b, expected 11111111 11111111", an, seg);
        end
        rst = 1'b0;
        @(negedge clk);
        push_frame(32'h0, 8'h00, 1'b0);
        check_frame("rst_mid");
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid pending survived: ready=%b, expected 1", bus.ready);
        end
    endtask

`ifdef SEGSCAN_BLINK_EN
    logic [BW-1:0] blink_model;

    always @(posedge clk) begin
        if (rst) blink_model <= '0;
        else     blink_model <= blink_model + 1'b1;
    end

    task automatic test_blink();
        logic [BW-1:0] prev;
        logic [7:0]    exp_seg;
        blink_mask = 8'h80;
        for (int c = 0; c < 64; c++) begin
            if (an === 8'hFE) begin
                prev    = blink_model - 1'b1;
                exp_seg = prev[BW-1] ? 8'hFF : 8'h03;
                tests_run++;
                if (seg !== exp_seg) begin
                    tests_failed++;
                    $display("FAIL blink pos0 cnt=%0d: seg=%b, expected %b", prev, seg, exp_seg);
                end else begin
                    $display("[TB] blink pos0 cnt=%0d seg=%b ok", prev, seg);
                end
            end
            @(negedge clk);
        end
        blink_mask = 8'h00;
    endtask
`else
    task automatic test_blink();
        blink_mask = 8'hFF;
        push_frame(32'h0, 8'h00, 1'b0);
        check_frame("blink_ignored");
        blink_mask = 8'h00;
    endtask
`endif

    initial begin
        bus.load    = 1'b0;
        bus.data_in = '0;
        bus.dp_in   = '0;
        lz_blank    = 1'b0;
        blink_mask  = '0;
        test_reset();
        test_data();
        test_lz();
        test_busy_load();
        test_reset_mid();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver that replaces the fixed 8-digit hex display path. It scans `NUM_DIGITS` common-anode digits at a programmable refresh rate, decodes hex nibbles to active-low segments, and drives per-digit decimal points. It also provides optional leading-zero suppression and tear-free updates through a load/ready handshake applied only at frame boundaries. It sits between the ALU result registers and the board's anode/segment pins.

## Interface

- `NUM_DIGITS`, 8: number of digits scanned, 1..16.
- `DIV_WIDTH`, 11: prescaler width; scan advances every 2^DIV_WIDTH clocks.
- `BLINK_WIDTH`, 24: blink counter width; blink phase is its MSB (only with `SEGSCAN_BLINK_EN`).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high, sampled on `posedge clk`.
- `load`  in  1  request to capture `data_in`/`dp_in`; accepted only when `ready`=1.
- `data_in`  in  4*NUM_DIGITS  hex nibbles; MS nibble is leftmost digit.
- `dp_in`  in  NUM_DIGITS  decimal point enables, bit i pairs with nibble i.
- `lz_blank`  in  1  leading-zero suppression enable (live, not latched).
- `blink_mask`  in  NUM_DIGITS  per-nibble blink enable (ignored without macro).
- `ready`  out  1  high when no update is pending.
- `an`  out  NUM_DIGITS  active-low one-hot anode select; `an[p]` is scan position p.
- `seg`  out  8  active-low {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp.
- `idx`  out  $clog2(NUM_DIGITS) (min 1)  current scan position.

## Operation

- Registers: `div_cnt`, `idx`, `disp` (display nibbles+dp), `pend` (pending nibbles+dp), `pend_v`, registered `an`/`seg`.
- Handshake: `load`&&`ready` captures `data_in`/`dp_in` into `pend`, sets `pend_v`; `ready` = !`pend_v`. `load` while `ready`=0 is ignored (pending data not overwritten).
- Commit: on the scan tick where `idx`==NUM_DIGITS-1 (wrap to 0), if `pend_v`, copy `pend`→`disp` and clear `pend_v`. Display never mixes old and new data within a frame.
- Same-cycle commit and `load`: the commit wins; `ready` is still 0 that cycle, so `load` is not accepted.
- Scan position p shows nibble NUM_DIGITS-1-p and dp bit NUM_DIGITS-1-p. Position 0 is the leftmost, most significant digit.
- Decode, active-low, bit7..1 = a..g: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, B→1100000, C→0110001, D→1000010, E→0110000, F→0111000. `seg[0]` = !dp.
- Leading-zero suppression (`lz_blank`=1): a position is blank when it and every position to its left hold nibble 0. Position NUM_DIGITS-1 is never suppressed. Blanked digit: `seg`=8'hFF; `an` still selects it; dp is also blanked.
- Wrap: `idx` counts 0..NUM_DIGITS-1 then 0; non-power-of-two `NUM_DIGITS` must not visit invalid indices.

## Timing

- Reset values: `div_cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_v`=0, `ready`=1, `an`=all 1s, `seg`=8'hFF.
- `div_cnt` increments every cycle; tick when `div_cnt` is all ones; `idx` advances on that edge.
- `an`/`seg` are registered from `idx` and `disp`: one-cycle latency after any `idx` or `disp` change. First valid `an` appears 1 cycle after `rst` deasserts.
- `ready` falls the cycle after an accepted `load` and rises the cycle after commit.
- Commit latency: up to NUM_DIGITS*2^DIV_WIDTH cycles after acceptance.
- `rst` mid-frame or with an update pending discards `pend`, clears `disp`, and returns to the reset values on the next edge.

## Configuration

- `SEGSCAN_BLINK_EN` defined: a free-running `BLINK_WIDTH` counter (reset 0) is built. While its MSB is 1, positions whose nibble has `blink_mask` set output `seg`=8'hFF. Blink blanking is applied after decode and LZ suppression.
- Undefined: no blink counter; `blink_mask` is unused; display is never blink-blanked.

## Test plan

- Reset: hold `rst` 3 cycles, release -> `an`=all 1s and `seg`=FF during reset; `ready`=1; then `an`=...1110, `seg`=00000011 (digit 0).
- NUM_DIGITS=8, DIV_WIDTH=2: `load` 0x12345678, `dp_in`=8'h01 -> after frame commit, positions 0..7 show 1..8 at 4 cycles each; position 7 `seg`=00000000.
- `lz_blank`=1, load 0x00000450 -> positions 0..4 `seg`=FF, positions 5,6,7 show 4,5,0. Load 0x00000000 -> only position 7 shows 00000011.
- Load during `ready`=0 with 0xAAAAAAAA after a pending 0x11111111 -> 0x11111111 displayed; `ready` returns 1 only at the frame wrap.
- Assert `rst` mid-frame with an update pending -> next cycle `ready`=1, `idx`=0, `disp`=0; the pending data never appears.
- With `SEGSCAN_BLINK_EN`, BLINK_WIDTH=4, `blink_mask`=8'h80 -> position 0 `seg`=FF while counter[3]=1, and decoded while counter[3]=0.
